divider_controller: RTL and testbench

Sequencing FSM for the 10-bit shift/subtract divider datapath. It drives the quotient shift register's init, `ldgt` and `lds` strobes and the remainder register load, one quotient bit per cycle from the comparator's greater-or-equal flag. It also supplies start/busy/done handshaking to the host. The block sits between the host logic and the divider datapath and contains no data-width arithmetic beyond its step counter.

---
 rtl/divider_controller.sv | 84 ++++++++
 tb/tb_divider_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_controller.sv
// Sequencing FSM for the shift/subtract divider: drives Q/remainder strobes and start/busy/done handshake.
// Optional divide-by-zero abort is built only when DIVZERO_CHECK_EN is defined.
module divider_controller #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gt,
    input  logic             dz,
    output logic             init,
    output logic             ldgt,
    output logic             lds,
    output logic             ld_sub,
    output logic             ld_sh,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] step
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_STEP, S_DONE, S_ERR} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t state;
    logic   run_en;
    logic   in_step;

    // Holds the FSM still for the first edge after reset release.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) run_en <= 1'b0;
        else        run_en <= 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step  <= '0;
        end else if (run_en) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_INIT;
                        step  <= '0;
                    end
                end
                S_INIT: begin
                    step <= '0;
`ifdef DIVZERO_CHECK_EN
                    state <= dz ? S_ERR : S_STEP;
`else
                    state <= S_STEP;
`endif
                end
                S_STEP: begin
                    if (step == LAST_STEP) state <= S_DONE;
                    else                   step  <= step + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_step = (state == S_STEP);
    assign init    = (state == S_INIT);
    assign ldgt    = in_step & gt;
    assign lds     = in_step & ~gt;
    assign ld_sub  = in_step & gt;
    assign ld_sh   = in_step & ~gt;
    assign busy    = (state == S_INIT) || (state == S_STEP);
    assign done    = (state == S_DONE);

`ifdef DIVZERO_CHECK_EN
    assign err = (state == S_ERR);
`else
    logic dz_unused;
    assign dz_unused = dz;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_divider_controller.sv
// Directed bench for divider_controller with a behavioural restoring-division datapath.
module tb_divider_controller;

    localparam int WIDTH = 10;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             start;
    logic             gt;
    logic             dz;
    logic             init, ldgt, lds, ld_sub, ld_sh, busy, done, err;
    logic [CNT_W-1:0] step;

    divider_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .start (start),
        .gt    (gt),
        .dz    (dz),
        .init  (init),
        .ldgt  (ldgt),
        .lds   (lds),
        .ld_sub(ld_sub),
        .ld_sh (ld_sh),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .step  (step)
    );

    always #5 clock = ~clock;

    // Behavioural datapath
    logic [WIDTH-1:0] dividend, divisor, q_reg, r_reg;
    logic [WIDTH:0]   shifted;
    logic             model_gt;
    int               gt_mode;

    assign shifted  = {r_reg, q_reg[WIDTH-1]};
    assign model_gt = (shifted >= {1'b0, divisor});
    assign gt       = (gt_mode == 1) ? 1'b1 : (gt_mode == 2) ? 1'b0 : model_gt;

    always_ff @(posedge clock) begin
        if (init) begin
            q_reg <= dividend;
            r_reg <= '0;
        end else begin
            if (ldgt)   q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            if (lds)    q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            if (ld_sub) r_reg <= WIDTH'(shifted - {1'b0, divisor});
            if (ld_sh)  r_reg <= shifted[WIDTH-1:0];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic rec_init [0:31];
    logic rec_done [0:31];
    logic rec_err  [0:31];
    logic rec_busy [0:31];
    int   rec_step [0:31];
    int   n_ldgt, n_lds, n_sub, n_sh, n_pair_bad;

    // Runs ncyc cycles; smask[c] is the start level during cycle c (cycle 0 ends at edge 0).
    task automatic run_job(input int dvd, input int dvs, input int gtm,
                           input logic [31:0] smask, input int ncyc);
        dividend = WIDTH'(dvd);
        divisor  = WIDTH'(dvs);
        gt_mode  = gtm;
        n_ldgt = 0; n_lds = 0; n_sub = 0; n_sh = 0; n_pair_bad = 0;
        @(negedge clock);
        start = smask[0];
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            rec_init[c] = init;
            rec_done[c] = done;
            rec_err[c]  = err;
            rec_busy[c] = busy;
            rec_step[c] = int'(step);
            if (ldgt)   n_ldgt++;
            if (lds)    n_lds++;
            if (ld_sub) n_sub++;
            if (ld_sh)  n_sh++;
            if ((ldgt && lds) || (ld_sub && ld_sh) || (ldgt != ld_sub) || (lds != ld_sh) ||
                ((busy && !init) != (ldgt || lds)))
                n_pair_bad++;
            start = smask[c];
        end
        start = 1'b0;
    endtask

    function automatic int first_hit(input int kind, input int from, input int ncyc);
        for (int c = from; c <= ncyc; c++) begin
            if (kind == 0 && rec_done[c]) return c;
            if (kind == 1 && rec_err[c])  return c;
            if (kind == 2 && rec_init[c]) return c;
        end
        return -1;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; dz = 1'b0; gt_mode = 0;
        dividend = '0; divisor = '1;
        #12;
        check("rst_outs", int'({init, ldgt, lds, ld_sub, ld_sh, busy, done, err}), 0);
        check("rst_step", int'(step), 0);
        @(negedge clock); rst_n = 1'b1;
        repeat (3) @(negedge clock);

        // 100 / 7 through the model
        run_job(100, 7, 0, 32'h1, 16);
        check("j1_init_c1", int'(rec_init[1]), 1);
        check("j1_busy_c1", int'(rec_busy[1]), 1);
        check("j1_busy_c11", int'(rec_busy[11]), 1);
        check("j1_step_c2", rec_step[2], 0);
        check("j1_step_c11", rec_step[11], 9);
        check("j1_step_c12", rec_step[12], 9);
        check("j1_done_cyc", first_hit(0, 1, 16), 12);
        check("j1_busy_c12", int'(rec_busy[12]), 0);
        check("j1_done_c13", int'(rec_done[13]), 0);
        check("j1_q", int'(q_reg), 14);
        check("j1_r", int'(r_reg), 2);
        check("j1_ldgt", n_ldgt, 3);
        check("j1_lds", n_lds, 7);
        check("j1_sub", n_sub, 3);
        check("j1_sh", n_sh, 7);
        check("j1_pair", n_pair_bad, 0);

        // gt forced high / low
        run_job(0, 1, 1, 32'h1, 14);
        check("g1_ldgt", n_ldgt, 10);
        check("g1_sub", n_sub, 10);
        check("g1_lds", n_lds, 0);
        check("g1_pair", n_pair_bad, 0);
        run_job(0, 1, 2, 32'h1, 14);
        check("g0_lds", n_lds, 10);
        check("g0_sh", n_sh, 10);
        check("g0_ldgt", n_ldgt, 0);
        check("g0_pair", n_pair_bad, 0);

        // start at cycles 4 and 12 (held into 13): no restart, new INIT at 14
        run_job(100, 7, 0, 32'h0000_3011, 16);
        check("sb_done_cyc", first_hit(0, 1, 16), 12);
        check("sb_init_next", first_hit(2, 2, 16), 14);
        check("sb_busy_c13", int'(rec_busy[13]), 0);
        repeat (14) @(negedge clock);

        // divide by zero
        dz = 1'b1;
        run_job(5, 0, 0, 32'h1, 14);
`ifdef DIVZERO_CHECK_EN
        check("dz_err_cyc", first_hit(1, 1, 14), 2);
        check("dz_no_done", first_hit(0, 1, 14), -1);
        check("dz_ldgt", n_ldgt + n_lds, 0);
        check("dz_busy_c3", int'(rec_busy[3]), 0);
`else
        check("dz_done_cyc", first_hit(0, 1, 14), 12);
        check("dz_no_err", first_hit(1, 1, 14), -1);
        check("dz_q_ones", int'(q_reg), (1 << WIDTH) - 1);
        check("dz_ldgt", n_ldgt, 10);
`endif
        dz = 1'b0;
        repeat (2) @(negedge clock);

        // async reset mid-STEP, then synchronous release
        dividend = 10'd100; divisor = 10'd7; gt_mode = 0;
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (6) @(negedge clock);
        check("mr_step5", int'(step), 5);
        #2 rst_n = 1'b0;
        #1;
        check("mr_outs", int'({init, ldgt, lds, ld_sub, ld_sh, busy, done, err}), 0);
        check("mr_step", int'(step), 0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1; start = 1'b1;
        @(negedge clock);
        check("mr_init_e1", int'(init), 0);
        @(negedge clock);
        check("mr_init_e2", int'(init), 1);
        start = 1'b0;
        repeat (14) @(negedge clock);
        check("mr_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
